fp_normalizer: RTL



---
 rtl/fp_normalizer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fp_normalizer.sv
// Two-stage valid/ready normalizer: leading-zero count in S1, shift and exponent adjust in S2.
// Optional macro NORM_DENORM_EN turns exponent underflow into a denormal instead of flush-to-zero.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [23:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_frac,
  output logic        out_zero,
  output logic        out_uflow,
  output logic        busy
);

  // Leading-zero count; returns 23 for both 0 and 1, so zero is flagged separately.
  function automatic logic [5:0] priencoder(input logic [23:0] mant);
    logic [5:0] lzc;
    lzc = 6'd23;
    for (int i = 0; i < 24; i++) begin
      if (mant[i]) begin
        lzc = 6'(23 - i);
      end
    end
    return lzc;
  endfunction

  logic        s1_valid_r;
  logic        s1_sign_r;
  logic [7:0]  s1_exp_r;
  logic [22:0] s1_mant_r;
  logic [5:0]  s1_lzc_r;
  logic        s1_zero_r;

  logic        s2_valid_r;
  logic        s2_sign_r;
  logic [7:0]  s2_exp_r;
  logic [22:0] s2_frac_r;
  logic        s2_zero_r;
  logic        s2_uflow_r;

  logic        s1_adv_s;
  logic        accept_s;
  logic [7:0]  nx_exp_s;
  logic [22:0] nx_frac_s;
  logic        nx_zero_s;
  logic        nx_uflow_s;
`ifdef NORM_DENORM_EN
  logic [7:0]  sh_s;
`endif

  assign s1_adv_s = s1_valid_r & (~s2_valid_r | out_ready);
  assign in_ready = ~s1_valid_r | s1_adv_s;
  assign accept_s = in_valid & in_ready;

  // Stage 1: capture the input fields with their leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= 8'd0;
      s1_mant_r  <= 23'd0;
      s1_lzc_r   <= 6'd0;
      s1_zero_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_sign_r  <= in_sign;
        s1_exp_r   <= in_exp;
        // Bit 23 always shifts out of the fraction, so it need not be kept.
        s1_mant_r  <= in_mant[22:0];
        s1_lzc_r   <= priencoder(in_mant);
        s1_zero_r  <= (in_mant == 24'd0);
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
    end
  end

  // Stage 2 datapath: normal shift, zero, or underflow handling.
  always_comb begin
    nx_exp_s   = 8'd0;
    nx_frac_s  = 23'd0;
    nx_zero_s  = 1'b0;
    nx_uflow_s = 1'b0;
`ifdef NORM_DENORM_EN
    sh_s       = 8'd0;
`endif
    if (s1_zero_r) begin
      nx_zero_s = 1'b1;
    end else if (s1_exp_r > {2'b00, s1_lzc_r}) begin
      nx_exp_s  = s1_exp_r - {2'b00, s1_lzc_r};
      nx_frac_s = s1_mant_r << s1_lzc_r;
    end else begin
      nx_uflow_s = 1'b1;
`ifdef NORM_DENORM_EN
      sh_s      = (s1_exp_r == 8'd0) ? 8'd0 : (s1_exp_r - 8'd1);
      nx_frac_s = s1_mant_r << sh_s;
`else
      nx_zero_s = 1'b1;
`endif
    end
  end

  // Stage 2 register: loads on S1 advance, empties when consumed without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_exp_r   <= 8'd0;
      s2_frac_r  <= 23'd0;
      s2_zero_r  <= 1'b0;
      s2_uflow_r <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s2_valid_r <= 1'b1;
        s2_sign_r  <= s1_sign_r;
        s2_exp_r   <= nx_exp_s;
        s2_frac_r  <= nx_frac_s;
        s2_zero_r  <= nx_zero_s;
        s2_uflow_r <= nx_uflow_s;
      end else if (out_ready) begin
        s2_valid_r <= 1'b0;
      end else begin
        s2_valid_r <= s2_valid_r;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_sign  = s2_sign_r;
  assign out_exp   = s2_exp_r;
  assign out_frac  = s2_frac_r;
  assign out_zero  = s2_zero_r;
  assign out_uflow = s2_uflow_r;
  assign busy      = s1_valid_r | s2_valid_r;

endmodule
